axis_width_converter: RTL and testbench

AXIS_WIDTH_CONVERTER -- requirements
Module: axis_width_converter

---
 rtl/axis_conv_pkg.sv | 24 ++
 rtl/axis_width_converter_if.sv | 32 +++
 rtl/axis_lane_select.sv | 23 ++
 rtl/axis_width_converter.sv | 222 ++++++++++++++++++++++
 tb/tb_axis_width_converter.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_conv_pkg.sv
// Shared constants and types for the AXI-Stream width converter.
// MODE encodings are 32-bit so "UP" and "DOWN" compare without width games.
package axis_conv_pkg;

  typedef logic [31:0] modeT;

  localparam modeT ModeUp   = {16'h0000, "UP"};
  localparam modeT ModeDown = "DOWN";

  typedef enum logic [0:0] {
    StEmpty,
    StEmit
  } downStateT;

  function automatic int unsigned ceilLog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_width_converter_if.sv
// AXI-Stream bundle; NBYTES sets the data width for one side of the converter.
interface axis_width_converter_if #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned USER_W = 8
);

  logic [NBYTES*8-1:0] tdata;
  logic [NBYTES-1:0]   tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata,
    output tkeep,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_lane_select.sv
// Priority encoder picking the lowest non-empty lane of a wide beat.
module axis_lane_select #(
  parameter int unsigned RATIO = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [RATIO-1:0] laneMask,
  output logic [IDX_W-1:0] laneSel,
  output logic             laneFound
);

  always_comb begin
    laneSel   = '0;
    laneFound = 1'b0;
    // Descending scan so the lowest set lane wins.
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (laneMask[i]) begin
        laneSel   = IDX_W'(i);
        laneFound = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_width_converter.sv
// AXI-Stream width converter: UP packs narrow beats into a wide word, DOWN splits
// wide beats into narrow ones, skipping empty lanes. Master outputs are registered.
module axis_width_converter
  import axis_conv_pkg::*;
#(
  parameter int unsigned NARROW_BYTES = 4,
  parameter int unsigned RATIO        = 2,
  parameter modeT        MODE         = ModeUp,
  parameter int unsigned USER_W       = 8
) (
  input  logic                   sysClk,
  input  logic                   resetN,
  axis_width_converter_if.slave  sAxiStream,
  axis_width_converter_if.master mAxiStream,
  output logic [15:0]            pktCount
);

  localparam int unsigned WIDE_BYTES = NARROW_BYTES * RATIO;
  localparam int unsigned SB         = (MODE == ModeDown) ? WIDE_BYTES : NARROW_BYTES;
  localparam int unsigned MB         = (MODE == ModeDown) ? NARROW_BYTES : WIDE_BYTES;
  localparam int unsigned IdxW       = ceilLog2(RATIO);
  localparam int unsigned LaneBits   = NARROW_BYTES * 8;

  logic [SB*8-1:0]   sData;
  logic [SB-1:0]     sKeep;
  logic [USER_W-1:0] sUser;
  logic              sLast;
  logic              sValid;
  logic              sReady;

  logic [MB*8-1:0]   outDataQ;
  logic [MB-1:0]     outKeepQ;
  logic [USER_W-1:0] outUserQ;
  logic              outLastQ;
  logic              outValidQ;
  logic              mReady;
  logic              mXfer;

  logic              readyEnQ;
  logic [15:0]       pktCountQ;

  assign sData  = sAxiStream.tdata;
  assign sKeep  = sAxiStream.tkeep;
  assign sUser  = sAxiStream.tuser;
  assign sLast  = sAxiStream.tlast;
  assign sValid = sAxiStream.tvalid;
  assign sAxiStream.tready = sReady;

  assign mAxiStream.tdata  = outDataQ;
  assign mAxiStream.tkeep  = outKeepQ;
  assign mAxiStream.tuser  = outUserQ;
  assign mAxiStream.tlast  = outLastQ;
  assign mAxiStream.tvalid = outValidQ;
  assign mReady            = mAxiStream.tready;

  assign mXfer    = outValidQ && mReady;
  assign pktCount = pktCountQ;

  // Holds the slave side closed while in reset; opens on the first edge after release.
  always_ff @(posedge sysClk or negedge resetN) begin
    if (!resetN) begin
      readyEnQ <= 1'b0;
    end else begin
      readyEnQ <= 1'b1;
    end
  end

  always_ff @(posedge sysClk or negedge resetN) begin
    if (!resetN) begin
      pktCountQ <= '0;
    end else if (mXfer && outLastQ) begin
      pktCountQ <= pktCountQ + 16'd1;
    end
  end

  if (MODE == ModeUp) begin : gUp
    logic [IdxW-1:0]         laneIdxQ;
    logic [WIDE_BYTES*8-1:0] asmDataQ;
    logic [WIDE_BYTES*8-1:0] wideData;
    logic [WIDE_BYTES-1:0]   asmKeepQ;
    logic [WIDE_BYTES-1:0]   wideKeep;
    logic                    sAccept;
    logic                    closeWord;

    assign sReady    = readyEnQ && (!outValidQ || mReady);
    assign sAccept   = sValid && sReady;
    assign closeWord = (laneIdxQ == IdxW'(RATIO - 1)) || sLast;

    // Lanes above laneIdxQ are still zero, which gives early-tlast words zero fill.
    always_comb begin
      wideData = asmDataQ;
      wideKeep = asmKeepQ;
      wideData[laneIdxQ*LaneBits +: LaneBits]         = sData;
      wideKeep[laneIdxQ*NARROW_BYTES +: NARROW_BYTES] = sKeep;
    end

    always_ff @(posedge sysClk or negedge resetN) begin
      if (!resetN) begin
        laneIdxQ  <= '0;
        asmDataQ  <= '0;
        asmKeepQ  <= '0;
        outDataQ  <= '0;
        outKeepQ  <= '0;
        outUserQ  <= '0;
        outLastQ  <= 1'b0;
        outValidQ <= 1'b0;
      end else begin
        if (mXfer) outValidQ <= 1'b0;
        if (sAccept) begin
          if (closeWord) begin
            outDataQ  <= wideData;
            outKeepQ  <= wideKeep;
            outUserQ  <= sUser;
            outLastQ  <= sLast;
            outValidQ <= 1'b1;
            laneIdxQ  <= '0;
            asmDataQ  <= '0;
            asmKeepQ  <= '0;
          end else begin
            asmDataQ <= wideData;
            asmKeepQ <= wideKeep;
            laneIdxQ <= laneIdxQ + 1'b1;
          end
        end
      end
    end
  end else if (MODE == ModeDown) begin : gDown
    downStateT               stateQ;
    logic [WIDE_BYTES*8-1:0] holdDataQ;
    logic [WIDE_BYTES*8-1:0] srcData;
    logic [WIDE_BYTES-1:0]   holdKeepQ;
    logic [WIDE_BYTES-1:0]   srcKeep;
    logic                    holdLastQ;
    logic [RATIO-1:0]        pendQ;
    logic [RATIO-1:0]        inMask;
    logic [RATIO-1:0]        selMask;
    logic [RATIO-1:0]        pendNext;
    logic [IdxW-1:0]         selIdx;
    logic                    selFound;
    logic                    useHold;
    logic                    sAccept;

    always_comb begin
      inMask = '0;
      for (int k = 0; k < RATIO; k++) begin
        inMask[k] = |sKeep[k*NARROW_BYTES +: NARROW_BYTES];
      end
    end

    // pendQ lists lanes of the held beat not yet presented; once empty, the encoder
    // looks at the incoming beat so it can be loaded as the last lane leaves.
    assign useHold = (stateQ == StEmit) && (pendQ != '0);
    assign selMask = useHold ? pendQ : inMask;
    assign srcData = useHold ? holdDataQ : sData;
    assign srcKeep = useHold ? holdKeepQ : sKeep;

    axis_lane_select #(
      .RATIO (RATIO),
      .IDX_W (IdxW)
    ) uLaneSelect (
      .laneMask  (selMask),
      .laneSel   (selIdx),
      .laneFound (selFound)
    );

    assign pendNext = selMask & ~(RATIO'(1) << selIdx);
    assign sReady   = readyEnQ && ((stateQ == StEmpty) || (mXfer && (pendQ == '0)));
    assign sAccept  = sValid && sReady;

    always_ff @(posedge sysClk or negedge resetN) begin
      if (!resetN) begin
        stateQ    <= StEmpty;
        holdDataQ <= '0;
        holdKeepQ <= '0;
        holdLastQ <= 1'b0;
        pendQ     <= '0;
        outDataQ  <= '0;
        outKeepQ  <= '0;
        outUserQ  <= '0;
        outLastQ  <= 1'b0;
        outValidQ <= 1'b0;
      end else begin
        if (mXfer) begin
          if (useHold) begin
            outDataQ <= srcData[selIdx*LaneBits +: LaneBits];
            outKeepQ <= srcKeep[selIdx*NARROW_BYTES +: NARROW_BYTES];
            outLastQ <= holdLastQ && (pendNext == '0);
            pendQ    <= pendNext;
          end else begin
            outValidQ <= 1'b0;
            stateQ    <= StEmpty;
          end
        end
        if (sAccept) begin
          holdDataQ <= sData;
          holdKeepQ <= sKeep;
          holdLastQ <= sLast;
          outUserQ  <= sUser;
          if (selFound) begin
            outDataQ  <= srcData[selIdx*LaneBits +: LaneBits];
            outKeepQ  <= srcKeep[selIdx*NARROW_BYTES +: NARROW_BYTES];
            outLastQ  <= sLast && (pendNext == '0);
            pendQ     <= pendNext;
            outValidQ <= 1'b1;
            stateQ    <= StEmit;
          end else if (sLast) begin
            // Empty closing beat still has to carry tlast downstream.
            outDataQ  <= '0;
            outKeepQ  <= '0;
            outLastQ  <= 1'b1;
            pendQ     <= '0;
            outValidQ <= 1'b1;
            stateQ    <= StEmit;
          end
        end
      end
    end
  end else begin : gBadMode
    $error("axis_width_converter: MODE must be \"UP\" or \"DOWN\"");
  end

endmodule

// File: tb/tb_axis_width_converter.sv
// Directed and backpressure bench for axis_width_converter, UP and DOWN instances side by side.
module tb_axis_width_converter;

  localparam int unsigned NB = 4;
  localparam int unsigned WB = 8;
  localparam int          NumPkts = 100;

  logic sysClk = 1'b0;
  logic resetN;
  always #5 sysClk = ~sysClk;

  axis_width_converter_if #(.NBYTES(NB), .USER_W(8)) upS ();
  axis_width_converter_if #(.NBYTES(WB), .USER_W(8)) upM ();
  axis_width_converter_if #(.NBYTES(WB), .USER_W(8)) dnS ();
  axis_width_converter_if #(.NBYTES(NB), .USER_W(8)) dnM ();

  logic [15:0] upPktCount;
  logic [15:0] dnPktCount;

  axis_width_converter #(
    .NARROW_BYTES (NB),
    .RATIO        (2),
    .MODE         (axis_conv_pkg::ModeUp),
    .USER_W       (8)
  ) dutUp (
    .sysClk     (sysClk),
    .resetN     (resetN),
    .sAxiStream (upS),
    .mAxiStream (upM),
    .pktCount   (upPktCount)
  );

  axis_width_converter #(
    .NARROW_BYTES (NB),
    .RATIO        (2),
    .MODE         (axis_conv_pkg::ModeDown),
    .USER_W       (8)
  ) dutDown (
    .sysClk     (sysClk),
    .resetN     (resetN),
    .sAxiStream (dnS),
    .mAxiStream (dnM),
    .pktCount   (dnPktCount)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic upDrive(input logic [31:0] d, input logic [3:0] k, input logic [7:0] u,
                         input logic l, input logic v);
    upS.tdata  = d;
    upS.tkeep  = k;
    upS.tuser  = u;
    upS.tlast  = l;
    upS.tvalid = v;
  endtask

  task automatic dnDrive(input logic [63:0] d, input logic [7:0] k, input logic [7:0] u,
                         input logic l, input logic v);
    dnS.tdata  = d;
    dnS.tkeep  = k;
    dnS.tuser  = u;
    dnS.tlast  = l;
    dnS.tvalid = v;
  endtask

  logic [7:0] upExp[$];
  logic [7:0] upGot[$];
  logic [7:0] dnExp[$];
  logic [7:0] dnGot[$];
  int upPkts = 0;
  int dnPkts = 0;
  int upStallBad = 0;
  int dnStallBad = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    resetN = 1'b0;
    upDrive('0, '0, '0, 1'b0, 1'b0);
    dnDrive('0, '0, '0, 1'b0, 1'b0);
    upM.tready = 1'b0;
    dnM.tready = 1'b0;
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);

    // Reset state
    checkEq("rst upValid", upM.tvalid, 0);
    checkEq("rst upData", upM.tdata, 0);
    checkEq("rst upKeep", upM.tkeep, 0);
    checkEq("rst upLast", upM.tlast, 0);
    checkEq("rst upUser", upM.tuser, 0);
    checkEq("rst upSReady", upS.tready, 0);
    checkEq("rst dnValid", dnM.tvalid, 0);
    checkEq("rst dnSReady", dnS.tready, 0);
    checkEq("rst upPktCount", upPktCount, 0);
    resetN = 1'b1;
    tick();
    checkEq("release upSReady", upS.tready, 1);
    checkEq("release dnSReady", dnS.tready, 1);

    // UP: two full beats, then an early-tlast single beat back to back
    upM.tready = 1'b1;
    upDrive(32'h1111_1111, 4'hF, 8'h01, 1'b0, 1'b1);
    tick();
    checkEq("up half word no valid", upM.tvalid, 0);
    upDrive(32'h2222_2222, 4'hF, 8'h03, 1'b1, 1'b1);
    tick();
    checkEq("up full valid", upM.tvalid, 1);
    checkEq("up full data", upM.tdata, 64'h2222_2222_1111_1111);
    checkEq("up full keep", upM.tkeep, 8'hFF);
    checkEq("up full last", upM.tlast, 1);
    checkEq("up full user", upM.tuser, 8'h03);
    upDrive(32'hAABB_CCDD, 4'hF, 8'h07, 1'b1, 1'b1);
    tick();
    checkEq("up pktCount 1", upPktCount, 1);
    checkEq("up early valid", upM.tvalid, 1);
    checkEq("up early data", upM.tdata, 64'h0000_0000_AABB_CCDD);
    checkEq("up early keep", upM.tkeep, 8'h0F);
    checkEq("up early user", upM.tuser, 8'h07);
    upDrive('0, '0, '0, 1'b0, 1'b0);
    tick();
    checkEq("up drained valid", upM.tvalid, 0);
    checkEq("up pktCount 2", upPktCount, 2);

    // DOWN: upper lane only, then a full beat with no bubble
    dnM.tready = 1'b1;
    dnDrive(64'h2222_2222_1111_1111, 8'hF0, 8'h05, 1'b1, 1'b1);
    tick();
    checkEq("dn skip valid", dnM.tvalid, 1);
    checkEq("dn skip data", dnM.tdata, 32'h2222_2222);
    checkEq("dn skip keep", dnM.tkeep, 4'hF);
    checkEq("dn skip last", dnM.tlast, 1);
    checkEq("dn skip user", dnM.tuser, 8'h05);
    checkEq("dn no bubble sReady", dnS.tready, 1);
    dnDrive(64'h4444_4444_3333_3333, 8'hFF, 8'h06, 1'b1, 1'b1);
    tick();
    checkEq("dn pktCount 1", dnPktCount, 1);
    checkEq("dn lane0 data", dnM.tdata, 32'h3333_3333);
    checkEq("dn lane0 last", dnM.tlast, 0);
    checkEq("dn lane0 user", dnM.tuser, 8'h06);
    checkEq("dn busy sReady", dnS.tready, 0);
    dnDrive('0, '0, '0, 1'b0, 1'b0);
    tick();
    checkEq("dn lane1 data", dnM.tdata, 32'h4444_4444);
    checkEq("dn lane1 last", dnM.tlast, 1);
    checkEq("dn lane1 user", dnM.tuser, 8'h06);
    tick();
    checkEq("dn drained valid", dnM.tvalid, 0);
    checkEq("dn pktCount 2", dnPktCount, 2);

    // DOWN: all-zero keep without and with tlast
    dnDrive(64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 8'h09, 1'b0, 1'b1);
    tick();
    checkEq("dn zero nolast valid", dnM.tvalid, 0);
    checkEq("dn zero nolast sReady", dnS.tready, 1);
    dnDrive(64'hBEEF_BEEF_BEEF_BEEF, 8'h00, 8'h0A, 1'b1, 1'b1);
    tick();
    checkEq("dn zero last valid", dnM.tvalid, 1);
    checkEq("dn zero last keep", dnM.tkeep, 0);
    checkEq("dn zero last last", dnM.tlast, 1);
    checkEq("dn zero last user", dnM.tuser, 8'h0A);
    dnDrive('0, '0, '0, 1'b0, 1'b0);
    tick();
    checkEq("dn pktCount 3", dnPktCount, 3);
    checkEq("dn zero last once", dnM.tvalid, 0);

    // Random packets under 50% backpressure in both modes
    fork
      begin : upProd
        int len;
        int guard;
        bit acc;
        logic [31:0] d;
        for (int p = 0; p < NumPkts; p++) begin
          len = $urandom_range(1, 5);
          for (int b = 0; b < len; b++) begin
            d = $urandom;
            upDrive(d, 4'hF, 8'(p), b == len - 1, 1'b1);
            for (int i = 0; i < 4; i++) upExp.push_back(d[i*8 +: 8]);
            guard = 0;
            do begin
              @(negedge sysClk);
              acc = upS.tready;
              tick();
              guard++;
            end while (!acc && guard < 200);
            if (!acc) checkEq("up accept timeout", 0, 1);
          end
        end
        upDrive('0, '0, '0, 1'b0, 1'b0);
      end
      begin : dnProd
        int len;
        int guard;
        bit acc;
        logic [63:0] d;
        logic [7:0]  k;
        for (int p = 0; p < NumPkts; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            d = {$urandom, $urandom};
            k = 8'($urandom);
            dnDrive(d, k, 8'(p), b == len - 1, 1'b1);
            for (int i = 0; i < 8; i++) if (k[i]) dnExp.push_back(d[i*8 +: 8]);
            guard = 0;
            do begin
              @(negedge sysClk);
              acc = dnS.tready;
              tick();
              guard++;
            end while (!acc && guard < 200);
            if (!acc) checkEq("dn accept timeout", 0, 1);
          end
        end
        dnDrive('0, '0, '0, 1'b0, 1'b0);
      end
      begin : upCons
        logic [63:0] hd;
        logic [7:0]  hk;
        logic [7:0]  hu;
        logic        hl;
        bit          stalled;
        int          cyc;
        stalled = 1'b0;
        cyc = 0;
        while (upPkts < NumPkts && cyc < 20000) begin
          @(negedge sysClk);
          if (stalled && (!upM.tvalid || upM.tdata !== hd || upM.tkeep !== hk ||
                          upM.tuser !== hu || upM.tlast !== hl)) upStallBad++;
          if (upM.tvalid && upM.tready) begin
            for (int i = 0; i < 8; i++) if (upM.tkeep[i]) upGot.push_back(upM.tdata[i*8 +: 8]);
            if (upM.tlast) upPkts++;
          end
          stalled = upM.tvalid && !upM.tready;
          hd = upM.tdata;
          hk = upM.tkeep;
          hu = upM.tuser;
          hl = upM.tlast;
          tick();
          upM.tready = 1'($urandom_range(0, 1));
          cyc++;
        end
        upM.tready = 1'b1;
      end
      begin : dnCons
        logic [31:0] hd;
        logic [3:0]  hk;
        logic [7:0]  hu;
        logic        hl;
        bit          stalled;
        int          cyc;
        stalled = 1'b0;
        cyc = 0;
        while (dnPkts < NumPkts && cyc < 20000) begin
          @(negedge sysClk);
          if (stalled && (!dnM.tvalid || dnM.tdata !== hd || dnM.tkeep !== hk ||
                          dnM.tuser !== hu || dnM.tlast !== hl)) dnStallBad++;
          if (dnM.tvalid && dnM.tready) begin
            for (int i = 0; i < 4; i++) if (dnM.tkeep[i]) dnGot.push_back(dnM.tdata[i*8 +: 8]);
            if (dnM.tlast) dnPkts++;
          end
          stalled = dnM.tvalid && !dnM.tready;
          hd = dnM.tdata;
          hk = dnM.tkeep;
          hu = dnM.tuser;
          hl = dnM.tlast;
          tick();
          dnM.tready = 1'($urandom_range(0, 1));
          cyc++;
        end
        dnM.tready = 1'b1;
      end
    join
    tick();

    checkEq("up bp packets", upPkts, NumPkts);
    checkEq("up bp byte count", upGot.size(), upExp.size());
    bad = 0;
    for (int i = 0; i < upExp.size() && i < upGot.size(); i++) if (upGot[i] !== upExp[i]) bad++;
    checkEq("up bp byte mismatches", bad, 0);
    checkEq("up bp stall stability", upStallBad, 0);
    checkEq("up bp pktCount", upPktCount, 2 + NumPkts);
    checkEq("dn bp packets", dnPkts, NumPkts);
    checkEq("dn bp byte count", dnGot.size(), dnExp.size());
    bad = 0;
    for (int i = 0; i < dnExp.size() && i < dnGot.size(); i++) if (dnGot[i] !== dnExp[i]) bad++;
    checkEq("dn bp byte mismatches", bad, 0);
    checkEq("dn bp stall stability", dnStallBad, 0);
    checkEq("dn bp pktCount", dnPktCount, 3 + NumPkts);

    // Reset mid-packet: partial UP word and held DOWN beat must vanish
    upM.tready = 1'b1;
    dnM.tready = 1'b0;
    upDrive(32'h5555_5555, 4'hF, 8'h00, 1'b0, 1'b1);
    dnDrive(64'h7777_7777_6666_6666, 8'hFF, 8'h00, 1'b1, 1'b1);
    tick();
    checkEq("pre-reset dn held valid", dnM.tvalid, 1);
    upDrive('0, '0, '0, 1'b0, 1'b0);
    dnDrive('0, '0, '0, 1'b0, 1'b0);
    #2 resetN = 1'b0;
    #1;
    checkEq("midrst upValid", upM.tvalid, 0);
    checkEq("midrst dnValid", dnM.tvalid, 0);
    checkEq("midrst dnData", dnM.tdata, 0);
    checkEq("midrst upPktCount", upPktCount, 0);
    checkEq("midrst dnPktCount", dnPktCount, 0);
    checkEq("midrst upSReady", upS.tready, 0);
    @(negedge sysClk);
    resetN = 1'b1;
    tick();
    checkEq("postrst upSReady", upS.tready, 1);
    checkEq("postrst dnSReady", dnS.tready, 1);
    checkEq("postrst dn no stale output", dnM.tvalid, 0);
    upDrive(32'h9999_9999, 4'hF, 8'h00, 1'b0, 1'b1);
    tick();
    upDrive(32'h8888_8888, 4'hF, 8'h0B, 1'b1, 1'b1);
    tick();
    checkEq("postrst up data", upM.tdata, 64'h8888_8888_9999_9999);
    checkEq("postrst up keep", upM.tkeep, 8'hFF);
    upDrive('0, '0, '0, 1'b0, 1'b0);
    dnM.tready = 1'b1;
    dnDrive(64'hBBBB_BBBB_AAAA_AAAA, 8'hFF, 8'h0C, 1'b1, 1'b1);
    tick();
    checkEq("postrst upPktCount", upPktCount, 1);
    checkEq("postrst dn lane0", dnM.tdata, 32'hAAAA_AAAA);
    dnDrive('0, '0, '0, 1'b0, 1'b0);
    tick();
    checkEq("postrst dn lane1", dnM.tdata, 32'hBBBB_BBBB);
    checkEq("postrst dn lane1 last", dnM.tlast, 1);
    tick();
    checkEq("postrst dnPktCount", dnPktCount, 1);

    // 65537 single-beat packets wrap pktCount to 1
    @(negedge sysClk);
    resetN = 1'b0;
    @(negedge sysClk);
    resetN = 1'b1;
    tick();
    upM.tready = 1'b1;
    upDrive(32'hC0FF_EE00, 4'hF, 8'h00, 1'b1, 1'b1);
    repeat (65537) @(posedge sysClk);
    #1;
    checkEq("wrap pktCount at 65536", upPktCount, 0);
    upDrive('0, '0, '0, 1'b0, 1'b0);
    tick();
    checkEq("wrap pktCount at 65537", upPktCount, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
